pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline latches (ID/EX, EX/MEM, MEM/WB).
- Carries a generic control vector and a data payload between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so upstream ready is fully registered.
- Adds flush (squash) and bubble semantics: control bits read zero whenever the output is not valid, so a bubble has no architectural side effects.

Parameters:
- CTRL_W, 12: width of the control vector (RegWrite, MemWrite, HLT, ...). Zeroed on flush, reset and bubble.
- DATA_W, 56: width of the payload (alu_out, write data, pc, rd, rt, ...). Never cleared except by reset.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; one clock.
- rst  in  1  reset; synchronous and active-low.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Handshake:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Payload and control are held stable while out_valid & !out_ready.
- Storage: main slot (head) plus skid slot.
- States, one-hot or encoded:
  - EMPTY: occupancy 0, in_ready 1, out_valid 0.
  - ONE: occupancy 1, in_ready 1, out_valid 1.
  - TWO: occupancy 2, in_ready 0, out_valid 1.
- Transitions, when flush=0:
  - EMPTY: accept -> ONE (main <= in).
  - ONE:
    - accept & pop -> ONE (main <= in).
    - accept & !pop -> TWO (skid <= in).
    - pop & !accept -> EMPTY.
  - TWO: pop -> ONE (main <= skid). No accept is possible because in_ready=0.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 per cycle with out_ready held high.
- in_ready is a flop: it equals (next state != TWO). There is no combinational path from out_ready to in_ready.
- Flush:
  - Highest priority after reset. Next state is EMPTY and both control slots are zeroed.
  - A simultaneous input is dropped; in_ready is still 1 in the flush cycle if it was 1.
  - A pop in the same cycle is still considered completed by downstream.
  - Payload slots retain stale data.
- Reset: when rst=0 at a clk edge:
  - state EMPTY, in_ready 1, out_valid 0.
  - out_ctrl 0, out_data 0, skid 0, occupancy 0.
  - Reset mid-transfer discards everything.
- Bubble rule: out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- Wrap/overflow: occupancy never exceeds 2. An accept while in TWO cannot occur; the bench asserts this.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined, two extra output ports and counters are present:
  - stall_cnt (CNT_W): counts cycles with out_valid & !out_ready.
  - bubble_cnt (CNT_W): counts cycles with out_ready & !out_valid.
  - Both saturate at all-ones.
  - Both are cleared by reset only; flush does not clear them.
- Without the macro: no ports, no counters. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef (PS_EMPTY, PS_ONE, PS_TWO);
  - default width constants (PIPE_CTRL_W=12, PIPE_DATA_W=56, PIPE_CNT_W=16);
  - the occupancy width constant.
- One sub-module, pipe_slot: a single entry register with load enable, synchronous ctrl clear and synchronous active-low reset. It is instantiated twice (main, skid).

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1, in_ctrl=12'hFFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, push ctrl 1,2,3 with data 0xA,0xB,0xC on consecutive cycles -> each appears 1 cycle later, in order, with no gaps.
- Backpressure: push 0x11 then 0x22, out_ready=0 -> occupancy=2 and in_ready=0 next cycle. Release out_ready -> 0x11 then 0x22 emitted and in_ready returns to 1.
- Flush with input: state TWO plus flush=1 and in_valid=1 (data 0x33) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x33 is never emitted.
- Bubble: after draining, out_ctrl=0 even though the main slot holds 12'hABC.
- PIPE_STAGE_PERF_EN: hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=3, 10 idle cycles -> bubble_cnt=7 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 12;
    localparam int PIPE_DATA_W = 56;
    localparam int PIPE_CNT_W  = 16;
    localparam int PIPE_OCC_W  = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [PIPE_OCC_W-1:0] occupancy_of(input pipe_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: control and payload registers with load enable.
// A clear zeroes only the control bits; the payload keeps its stale value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Clear beats load so a squashed entry can never carry live control bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clear) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble masking.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = PIPE_CNT_W
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
`endif
);

    pipe_state_t       state, state_nxt;
    logic              accept, pop;
    logic              main_load, main_from_skid, skid_load;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;

    assign out_valid = (state != PS_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_nxt = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (accept) begin
                        state_nxt = PS_ONE;
                        main_load = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = PS_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (pop) begin
                        state_nxt      = PS_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    // in_ready is computed from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= PS_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != PS_TWO);
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (flush),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (flush),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign out_data  = main_data;
    assign occupancy = occupancy_of(state);

`ifdef PIPE_STAGE_PERF_EN
    // Counters saturate rather than wrap and survive a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (out_ready && !out_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table plus an in-order scoreboard.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = PIPE_CTRL_W;
    localparam int DW = PIPE_DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   stall_cnt, bubble_cnt;
    logic [2:0]    p_stall, p_bubble;
    logic          p_in_ready, p_out_valid;
    logic [CW-1:0] p_out_ctrl;
    logic [DW-1:0] p_out_data;
    logic [1:0]    p_occ;
`endif

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

`ifdef PIPE_STAGE_PERF_EN
    // Idle instance with narrow counters, always ready downstream, to exercise saturation.
    pipe_stage_skid #(.CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (1'b0),
        .in_ready  (p_in_ready),
        .in_ctrl   ({CW{1'b0}}),
        .in_data   ({DW{1'b0}}),
        .out_valid (p_out_valid),
        .out_ready (1'b1),
        .out_ctrl  (p_out_ctrl),
        .out_data  (p_out_data),
        .occupancy (p_occ),
        .stall_cnt (p_stall),
        .bubble_cnt(p_bubble)
    );
`endif

    typedef struct {
        logic          rst, flush, iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ov;
        logic [CW-1:0] oc;
        logic          chkData;
        logic [DW-1:0] od;
        logic          ir;
        logic [1:0]    occ;
    } vec_t;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } item_t;

    vec_t  vecs[$];
    item_t sbq[$];
    int    nChecks = 0;
    int    nFails  = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [CW-1:0] ic, input logic [DW-1:0] id,
                                input logic ordy, input logic ov, input logic [CW-1:0] oc,
                                input logic cd, input logic [DW-1:0] od,
                                input logic ir, input logic [1:0] occ);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.ov = ov; v.oc = oc; v.chkData = cd; v.od = od; v.ir = ir; v.occ = occ;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs on the falling edge: accepted inputs are queued, popped heads are compared.
    task automatic scoreboardStep();
        item_t it;
        if (!rst) begin
            sbq.delete();
        end else begin
            if (!out_valid) checkValue("bubble_ctrl", 64'(out_ctrl), 64'd0);
            checkValue("full_blocks_input", 64'(in_ready), 64'(occupancy != 2'd2));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkValue("unexpected_output", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    it = sbq.pop_front();
                    checkValue("sb_ctrl", 64'(out_ctrl), 64'(it.ctrl));
                    checkValue("sb_data", 64'(out_data), 64'(it.data));
                end
            end
            if (flush) sbq.delete();
            else if (in_valid && in_ready) sbq.push_back('{ctrl: in_ctrl, data: in_data});
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        flush     = v.flush;
        in_valid  = v.iv;
        in_ctrl   = v.ic;
        in_data   = v.id;
        out_ready = v.ordy;
        @(negedge clk);
        scoreboardStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkValue($sformatf("v%0d.out_valid", idx), 64'(out_valid), 64'(v.ov));
        checkValue($sformatf("v%0d.out_ctrl", idx),  64'(out_ctrl),  64'(v.oc));
        if (v.chkData) checkValue($sformatf("v%0d.out_data", idx), 64'(out_data), 64'(v.od));
        checkValue($sformatf("v%0d.in_ready", idx),  64'(in_ready),  64'(v.ir));
        checkValue($sformatf("v%0d.occupancy", idx), 64'(occupancy), 64'(v.occ));
    endtask

    initial begin
        //               rst f  iv ctrl     data       ordy ov ctrl     cd data      ir occ
        vecs.push_back(mk(0, 0, 1, 12'hFFF, 56'hDEAD,  0,   0, 12'h000, 1, 56'h0,    1, 2'd0));
        vecs.push_back(mk(0, 0, 1, 12'hFFF, 56'hDEAD,  0,   0, 12'h000, 1, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'h001, 56'hA,     1,   1, 12'h001, 1, 56'hA,    1, 2'd1));
        vecs.push_back(mk(1, 0, 1, 12'h002, 56'hB,     1,   1, 12'h002, 1, 56'hB,    1, 2'd1));
        vecs.push_back(mk(1, 0, 1, 12'h003, 56'hC,     1,   1, 12'h003, 1, 56'hC,    1, 2'd1));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'h005, 56'h11,    0,   1, 12'h005, 1, 56'h11,   1, 2'd1));
        vecs.push_back(mk(1, 0, 1, 12'h006, 56'h22,    0,   1, 12'h005, 1, 56'h11,   0, 2'd2));
        vecs.push_back(mk(1, 0, 1, 12'h007, 56'h99,    0,   1, 12'h005, 1, 56'h11,   0, 2'd2));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   1, 12'h006, 1, 56'h22,   1, 2'd1));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'h008, 56'h44,    0,   1, 12'h008, 1, 56'h44,   1, 2'd1));
        vecs.push_back(mk(1, 0, 1, 12'h009, 56'h55,    0,   1, 12'h008, 1, 56'h44,   0, 2'd2));
        vecs.push_back(mk(1, 1, 1, 12'h00A, 56'h33,    0,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'h00B, 56'h66,    0,   1, 12'h00B, 1, 56'h66,   1, 2'd1));
        vecs.push_back(mk(1, 1, 1, 12'h00C, 56'h77,    1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'hABC, 56'hABC,   1,   1, 12'hABC, 1, 56'hABC,  1, 2'd1));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 0, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 1, 12'h00D, 56'hD1,    0,   1, 12'h00D, 1, 56'hD1,   1, 2'd1));
        vecs.push_back(mk(1, 0, 1, 12'h00E, 56'hE1,    0,   1, 12'h00D, 1, 56'hD1,   0, 2'd2));
        vecs.push_back(mk(0, 0, 0, 12'h000, 56'h0,     0,   0, 12'h000, 1, 56'h0,    1, 2'd0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 56'h0,     1,   0, 12'h000, 1, 56'h0,    1, 2'd0));

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        checkValue("sb_empty_after_table", 64'(sbq.size()), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
        $display("[TB] performance counter sequence");
        applyStimulus(mk(0, 0, 0, 12'h000, 56'h0, 0, 0, 12'h000, 0, 56'h0, 1, 2'd0));
        checkValue("stall_cnt_reset",  64'(stall_cnt),  64'd0);
        checkValue("bubble_cnt_reset", 64'(bubble_cnt), 64'd0);
        applyStimulus(mk(1, 0, 1, 12'h001, 56'h1, 0, 0, 12'h000, 0, 56'h0, 1, 2'd0));
        for (int c = 0; c < 5; c++)
            applyStimulus(mk(1, 0, 0, 12'h000, 56'h0, 0, 0, 12'h000, 0, 56'h0, 1, 2'd0));
        checkValue("stall_cnt_5",  64'(stall_cnt),  64'd5);
        checkValue("bubble_cnt_0", 64'(bubble_cnt), 64'd0);
        for (int c = 0; c < 4; c++)
            applyStimulus(mk(1, 0, 0, 12'h000, 56'h0, 0, 0, 12'h000, 0, 56'h0, 1, 2'd0));
        checkValue("sat_bubble_cnt", 64'(p_bubble), 64'd7);
        checkValue("sat_stall_cnt",  64'(p_stall),  64'd0);
        checkValue("sat_idle_valid", 64'(p_out_valid), 64'd0);
        checkValue("sat_idle_ready", 64'(p_in_ready),  64'd1);
        checkValue("sat_idle_occ",   64'(p_occ),       64'd0);
        checkValue("sat_idle_ctrl",  64'(p_out_ctrl),  64'd0);
        checkValue("sat_idle_data",  64'(p_out_data),  64'd0);
        applyStimulus(mk(1, 1, 0, 12'h000, 56'h0, 1, 0, 12'h000, 0, 56'h0, 1, 2'd0));
        checkValue("stall_cnt_kept_on_flush", 64'(stall_cnt), 64'd9);
        checkValue("occ_after_flush",         64'(occupancy), 64'd0);
        checkValue("sb_empty_after_perf",     64'(sbq.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
